fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Control block that sequences the 8-bit program counter / instruction-fetch stage. Converts pipeline events (taken jump/branch, load-use hazard, halt/resume) into the PC's `pc_mux_sel`, `jmp_loc`, `stall` and `stall_pm` controls, plus a `flush` to squash wrong-path instructions. Sits between the decode/execute hazard logic and the program counter module, and keeps a saturating stall-cycle counter for debug.

## Interface
- `FLUSH_CYCLES`, default 2: cycles `flush` is held after a redirect; legal range 1..15.
- `HAZARD_STALL`, default 1: cycles `stall`/`stall_pm` are held per hazard; legal range 1..15.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `jmp_req`  in  1  taken jump/branch resolved this cycle.
- `jmp_target`  in  8  jump destination address, valid with `jmp_req`.
- `hazard`  in  1  load-use hazard detected in decode.
- `halt`  in  1  halt instruction decoded.
- `resume`  in  1  restart fetch after halt.
- `pc_mux_sel`  out  1  select `jmp_loc` as the PC source.
- `jmp_loc`  out  8  registered jump address to the PC.
- `stall`  out  1  hold the current PC address.
- `stall_pm`  out  1  hold the fetched instruction register.
- `flush`  out  1  replace IF/ID and ID/EX contents with NOP.
- `state`  out  2  FSM state: RUN=0, STALL=1, REDIRECT=2, HALT=3.
- `stall_cycles`  out  16  saturating count of cycles with `stall`=1.

## Operation
- All outputs are registered. No combinational path runs from inputs to outputs.
- FSM with a 4-bit down-counter `cnt`.
- **RUN**: all controls are 0. Inputs are sampled on each rising edge, highest priority first:
  - `jmp_req` → REDIRECT. Latch `jmp_loc`=`jmp_target`, `cnt`=FLUSH_CYCLES-1.
  - else `hazard` → STALL, `cnt`=HAZARD_STALL-1.
  - else `halt` → HALT.
- **STALL**: `stall`=`stall_pm`=1.
  - `jmp_req` → REDIRECT immediately. The stall is aborted and the target is latched.
  - else if `cnt`=0 → RUN.
  - else `cnt` decrements.
  - `hazard` and `halt` are ignored in this state.
- **REDIRECT**: `flush`=1 every cycle in the state. `pc_mux_sel`=1 only in the first cycle.
  - `stall`=`stall_pm`=0.
  - `cnt`=0 → RUN, else `cnt` decrements.
  - A new `jmp_req` restarts REDIRECT with the new target; `pc_mux_sel` pulses again.
  - `hazard` and `halt` are ignored (wrong-path instructions).
- **HALT**: `stall`=`stall_pm`=1 indefinitely.
  - `resume` → RUN.
  - `jmp_req`, `hazard` and `halt` are ignored.
- `jmp_loc` holds its last latched value outside REDIRECT.
- `stall_cycles` increments on each clock where the registered `stall` is 1 and saturates at 0xFFFF.
- Reset is asynchronous and active-low:
  - state=RUN, `cnt`=0, `jmp_loc`=0x00, `stall_cycles`=0.
  - `pc_mux_sel`, `stall`, `stall_pm` and `flush` all =0.
  - Reset asserted mid-operation aborts any state at once.

## Timing
- Event sampled at edge N → outputs change after edge N (visible during cycle N+1).
- Jump:
  - `pc_mux_sel`=1 and `jmp_loc` valid for exactly cycle N+1.
  - `flush`=1 for cycles N+1..N+FLUSH_CYCLES.
  - Back in RUN from cycle N+FLUSH_CYCLES+1.
- Hazard: `stall`=`stall_pm`=1 for cycles N+1..N+HAZARD_STALL, RUN from N+HAZARD_STALL+1.
  - A hazard asserted again in the first RUN cycle starts a new stall.
- Halt: `stall`=1 from N+1 through the cycle in which `resume` is sampled, and 0 on the following cycle.
- Jump and hazard at the same edge: the jump wins and no stall occurs.
- Jump during STALL at edge M: `stall`=0 and `pc_mux_sel`=1 in cycle M+1.
- Reset release: the first edge with `reset`=1 samples inputs normally.

## Test plan
- Reset, then drive `jmp_req`=1 with `jmp_target`=0x3C for one cycle. Next cycle requires `pc_mux_sel`=1 and `jmp_loc`=0x3C. `flush`=1 for exactly 2 cycles, then state=0.
- Pulse `hazard` for one cycle (HAZARD_STALL=1) → `stall`=`stall_pm`=1 for exactly 1 cycle and `stall_cycles`=1. Repeat with HAZARD_STALL=3 → `stall`=1 for 3 cycles.
- Same edge: `jmp_req`=1 (`jmp_target`=0x10) and `hazard`=1 → REDIRECT, `stall` never asserted, `jmp_loc`=0x10. Then `jmp_req`=1 (`jmp_target`=0x22) one cycle after the first → `pc_mux_sel` pulses again, `jmp_loc`=0x22, `flush` extends 2 cycles from the second pulse.
- HAZARD_STALL=3, hazard, then `jmp_req`=1 (0x05) during the 2nd stall cycle → `stall`=0 and `pc_mux_sel`=1, `jmp_loc`=0x05 on the next cycle.
- `halt`, hold 10 cycles with `jmp_req` and `hazard` toggling → state=3, `stall`=1, `jmp_loc` unchanged. `resume` → state=0 next cycle, `stall_cycles`=11.
- Assert `reset`=0 asynchronously mid-REDIRECT → all outputs 0 and state=0 before the next edge. Force `stall_cycles` to saturation with a long halt → holds at 0xFFFF.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch-stage control sequencer: turns jump/hazard/halt events into registered
// PC mux, stall and flush controls, and counts stalled cycles for debug.
module fetch_sequencer #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned HAZARD_STALL = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jmp_req,
    input  logic [7:0]  jmp_target,
    input  logic        hazard,
    input  logic        halt,
    input  logic        resume,
    output logic        pc_mux_sel,
    output logic [7:0]  jmp_loc,
    output logic        stall,
    output logic        stall_pm,
    output logic        flush,
    output logic [1:0]  state,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [3:0] STALL_LOAD = 4'(HAZARD_STALL - 1);

    state_t     st_q, st_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] jmp_loc_d;
    logic       redirect_go;

    always_comb begin
        st_d        = st_q;
        cnt_d       = cnt_q;
        jmp_loc_d   = jmp_loc;
        redirect_go = 1'b0;
        case (st_q)
            RUN: begin
                if (jmp_req) begin
                    redirect_go = 1'b1;
                end else if (hazard) begin
                    st_d  = STALL;
                    cnt_d = STALL_LOAD;
                end else if (halt) begin
                    st_d = HALT;
                end
            end
            STALL: begin
                if (jmp_req) begin
                    redirect_go = 1'b1;
                end else if (cnt_q == '0) begin
                    st_d = RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            REDIRECT: begin
                if (jmp_req) begin
                    redirect_go = 1'b1;
                end else if (cnt_q == '0) begin
                    st_d = RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HALT: begin
                if (resume) begin
                    st_d = RUN;
                end
            end
            default: st_d = RUN;
        endcase
        // Any accepted jump (re)enters REDIRECT with a fresh flush window
        if (redirect_go) begin
            st_d      = REDIRECT;
            cnt_d     = FLUSH_LOAD;
            jmp_loc_d = jmp_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q         <= RUN;
            cnt_q        <= '0;
            jmp_loc      <= '0;
            pc_mux_sel   <= 1'b0;
            stall        <= 1'b0;
            stall_pm     <= 1'b0;
            flush        <= 1'b0;
            stall_cycles <= '0;
        end else begin
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            jmp_loc    <= jmp_loc_d;
            pc_mux_sel <= redirect_go;
            stall      <= (st_d == STALL) || (st_d == HALT);
            stall_pm   <= (st_d == STALL) || (st_d == HALT);
            flush      <= (st_d == REDIRECT);
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: default instance plus a HAZARD_STALL=3 instance
// sharing the same stimulus; expected values are hand-computed per cycle.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       jmp_req;
    logic [7:0] jmp_target;
    logic       hazard;
    logic       halt;
    logic       resume;

    logic        pms1, st1, sp1, fl1;
    logic [7:0]  jl1;
    logic [1:0]  state1;
    logic [15:0] sc1;
    logic        pms3, st3, sp3, fl3;
    logic [7:0]  jl3;
    logic [1:0]  state3;
    logic [15:0] sc3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut1 (
        .clk(clk), .reset(reset), .jmp_req(jmp_req), .jmp_target(jmp_target),
        .hazard(hazard), .halt(halt), .resume(resume),
        .pc_mux_sel(pms1), .jmp_loc(jl1), .stall(st1), .stall_pm(sp1),
        .flush(fl1), .state(state1), .stall_cycles(sc1)
    );

    fetch_sequencer #(.FLUSH_CYCLES(2), .HAZARD_STALL(3)) dut3 (
        .clk(clk), .reset(reset), .jmp_req(jmp_req), .jmp_target(jmp_target),
        .hazard(hazard), .halt(halt), .resume(resume),
        .pc_mux_sel(pms3), .jmp_loc(jl3), .stall(st3), .stall_pm(sp3),
        .flush(fl3), .state(state3), .stall_cycles(sc3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        jmp_req    = 1'b0;
        jmp_target = 8'h00;
        hazard     = 1'b0;
        halt       = 1'b0;
        resume     = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_state", state1, 0);
        chk("rst_pms", pms1, 0);
        chk("rst_jl", jl1, 8'h00);
        chk("rst_stall", st1, 0);
        chk("rst_flush", fl1, 0);
        chk("rst_sc", sc1, 0);

        // jump to 0x3C
        jmp_req = 1'b1; jmp_target = 8'h3C;
        tick(); clear_inputs();
        chk("j1_pms", pms1, 1);
        chk("j1_jl", jl1, 8'h3C);
        chk("j1_flush", fl1, 1);
        chk("j1_state", state1, 2);
        chk("j1_stall", st1, 0);
        tick();
        chk("j2_pms", pms1, 0);
        chk("j2_flush", fl1, 1);
        chk("j2_jl", jl1, 8'h3C);
        tick();
        chk("j3_flush", fl1, 0);
        chk("j3_state", state1, 0);

        // single hazard pulse
        hazard = 1'b1;
        tick(); clear_inputs();
        chk("h1_stall", st1, 1);
        chk("h1_stall_pm", sp1, 1);
        chk("h1_state", state1, 1);
        chk("h3_c1_stall", st3, 1);
        tick();
        chk("h1_end_stall", st1, 0);
        chk("h1_end_state", state1, 0);
        chk("h1_sc", sc1, 1);
        chk("h3_c2_stall", st3, 1);
        tick();
        chk("h3_c3_stall", st3, 1);
        tick();
        chk("h3_end_stall", st3, 0);
        chk("h3_end_state", state3, 0);
        chk("h3_sc", sc3, 3);

        // jump and hazard together, then back-to-back jump
        jmp_req = 1'b1; jmp_target = 8'h10; hazard = 1'b1;
        tick();
        hazard = 1'b0; jmp_target = 8'h22;
        chk("jh_stall", st1, 0);
        chk("jh_pms", pms1, 1);
        chk("jh_jl", jl1, 8'h10);
        chk("jh_state", state1, 2);
        tick(); clear_inputs();
        chk("jj_pms", pms1, 1);
        chk("jj_jl", jl1, 8'h22);
        chk("jj_flush", fl1, 1);
        chk("jj_stall", st1, 0);
        tick();
        chk("jj2_pms", pms1, 0);
        chk("jj2_flush", fl1, 1);
        tick();
        chk("jj3_flush", fl1, 0);
        chk("jj3_state", state1, 0);

        // jump aborting a 3-cycle stall in its 2nd cycle
        hazard = 1'b1;
        tick(); clear_inputs();
        chk("sa_c1_stall", st3, 1);
        tick();
        chk("sa_c2_stall", st3, 1);
        jmp_req = 1'b1; jmp_target = 8'h05;
        tick(); clear_inputs();
        chk("sa_stall", st3, 0);
        chk("sa_pms", pms3, 1);
        chk("sa_jl", jl3, 8'h05);
        chk("sa_state", state3, 2);
        tick(); tick(); tick();

        // halt with jump/hazard noise, then resume
        do_reset();
        halt = 1'b1;
        tick(); clear_inputs();
        chk("halt_state", state1, 3);
        chk("halt_stall", st1, 1);
        for (int i = 0; i < 10; i++) begin
            jmp_req    = (i % 2 == 0);
            hazard     = (i % 2 != 0);
            jmp_target = 8'hAA;
            tick();
            chk("halt_hold_state", state1, 3);
            chk("halt_hold_stall", st1, 1);
            chk("halt_hold_jl", jl1, 8'h00);
        end
        clear_inputs();
        resume = 1'b1;
        tick(); clear_inputs();
        chk("resume_state", state1, 0);
        chk("resume_stall", st1, 0);
        chk("resume_sc", sc1, 11);

        // async reset in the middle of a redirect
        jmp_req = 1'b1; jmp_target = 8'h77;
        tick(); clear_inputs();
        chk("ar_pre_flush", fl1, 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_state", state1, 0);
        chk("ar_flush", fl1, 0);
        chk("ar_pms", pms1, 0);
        chk("ar_jl", jl1, 8'h00);
        chk("ar_stall", st1, 0);
        chk("ar_sc", sc1, 0);
        tick();
        reset = 1'b1;

        // saturate the stall counter with a long halt
        halt = 1'b1;
        tick(); clear_inputs();
        repeat (65534) tick();
        chk("sat_pre", sc1, 16'hFFFE);
        tick();
        chk("sat_hit", sc1, 16'hFFFF);
        tick();
        chk("sat_hold", sc1, 16'hFFFF);
        resume = 1'b1;
        tick(); clear_inputs();
        tick();
        chk("sat_after_resume", sc1, 16'hFFFF);
        chk("sat_state", state1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
